// File: rtl/uart_tx_fifo.sv
// Buffered UART transmitter: a DEPTH-entry byte FIFO feeding an 8N1 / 8O1 / 8E1 serialiser.
// Bytes are popped straight from the FIFO head, so back-to-back frames need no idle gap.
module uart_tx_fifo #(
  parameter int CLK_FREQ = 50_000_000,
  parameter int BAUD     = 115200,
  parameter int DEPTH    = 16,
  parameter int PARITY   = 0
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     wr_en,
  input  logic [7:0]               wr_data,
  output logic                     full,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     overflow,
  output logic                     busy,
  output logic                     tx
);

  localparam int BAUD_DIV = CLK_FREQ / BAUD;
  localparam int AW       = $clog2(DEPTH);
  localparam int CW       = $clog2(BAUD_DIV);

  localparam logic [CW-1:0] BAUD_LAST = CW'(BAUD_DIV - 1);
  localparam logic [CW-1:0] BAUD_ONE  = CW'(1);
  localparam logic [AW:0]   CNT_FULL  = (AW + 1)'(DEPTH);
  localparam logic [AW:0]   CNT_ONE   = (AW + 1)'(1);
  localparam logic [AW-1:0] PTR_ONE   = AW'(1);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_START = 3'd1;
  localparam logic [2:0] S_DATA  = 3'd2;
  localparam logic [2:0] S_PAR   = 3'd3;
  localparam logic [2:0] S_STOP  = 3'd4;

  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr_reg, wr_ptr_next;
  logic [AW-1:0] rd_ptr_reg, rd_ptr_next;
  logic [AW:0]   count_reg, count_next;
  logic          overflow_reg, overflow_next;

  logic [2:0]    state_reg, state_next;
  logic [CW-1:0] baud_cnt_reg, baud_cnt_next;
  logic [2:0]    bit_idx_reg, bit_idx_next;
  logic [7:0]    shift_reg, shift_next;
  logic          parity_reg, parity_next;
  logic          tx_reg, tx_next;

  logic          full_int;
  logic          push;
  logic          pop;
  logic          load;
  logic          baud_end;
  logic [7:0]    head;

  // Full is taken from the registered count, so a pop on the same edge never frees a slot early.
  assign full_int = (count_reg == CNT_FULL);
  assign push     = wr_en && !full_int;
  assign baud_end = (baud_cnt_reg == BAUD_LAST);
  // Head is read combinationally so the pop edge can load the shifter directly.
  assign head     = mem[rd_ptr_reg];

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr_reg] <= wr_data;
    end
  end

  always_comb begin
    state_next    = state_reg;
    baud_cnt_next = baud_end ? '0 : baud_cnt_reg + BAUD_ONE;
    bit_idx_next  = bit_idx_reg;
    shift_next    = shift_reg;
    parity_next   = parity_reg;
    tx_next       = tx_reg;
    load          = 1'b0;

    case (state_reg)
      S_IDLE: begin
        baud_cnt_next = '0;
        tx_next       = 1'b1;
        if (count_reg != '0) begin
          load = 1'b1;
        end
      end
      S_START: begin
        if (baud_end) begin
          state_next   = S_DATA;
          tx_next      = shift_reg[0];
          bit_idx_next = '0;
        end
      end
      S_DATA: begin
        if (baud_end) begin
          if (bit_idx_reg == 3'd7) begin
            if (PARITY != 0) begin
              state_next = S_PAR;
              tx_next    = parity_reg;
            end else begin
              state_next = S_STOP;
              tx_next    = 1'b1;
            end
          end else begin
            shift_next   = {1'b0, shift_reg[7:1]};
            tx_next      = shift_reg[1];
            bit_idx_next = bit_idx_reg + 3'd1;
          end
        end
      end
      S_PAR: begin
        if (baud_end) begin
          state_next = S_STOP;
          tx_next    = 1'b1;
        end
      end
      S_STOP: begin
        if (baud_end) begin
          if (count_reg != '0) begin
            load = 1'b1;
          end else begin
            state_next = S_IDLE;
            tx_next    = 1'b1;
          end
        end
      end
      default: begin
        state_next = S_IDLE;
        tx_next    = 1'b1;
      end
    endcase

    // Common frame launch from IDLE or straight out of STOP.
    if (load) begin
      shift_next    = head;
      parity_next   = (PARITY == 1) ? ~^head : ^head;
      state_next    = S_START;
      tx_next       = 1'b0;
      baud_cnt_next = '0;
    end
  end

  assign pop = load;

  always_comb begin
    wr_ptr_next   = push ? wr_ptr_reg + PTR_ONE : wr_ptr_reg;
    rd_ptr_next   = pop  ? rd_ptr_reg + PTR_ONE : rd_ptr_reg;
    overflow_next = overflow_reg | (wr_en & full_int);
    case ({push, pop})
      2'b10:   count_next = count_reg + CNT_ONE;
      2'b01:   count_next = count_reg - CNT_ONE;
      default: count_next = count_reg;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_reg   <= '0;
      rd_ptr_reg   <= '0;
      count_reg    <= '0;
      overflow_reg <= 1'b0;
      state_reg    <= S_IDLE;
      baud_cnt_reg <= '0;
      bit_idx_reg  <= '0;
      shift_reg    <= '0;
      parity_reg   <= 1'b0;
      tx_reg       <= 1'b1;
    end else begin
      wr_ptr_reg   <= wr_ptr_next;
      rd_ptr_reg   <= rd_ptr_next;
      count_reg    <= count_next;
      overflow_reg <= overflow_next;
      state_reg    <= state_next;
      baud_cnt_reg <= baud_cnt_next;
      bit_idx_reg  <= bit_idx_next;
      shift_reg    <= shift_next;
      parity_reg   <= parity_next;
      tx_reg       <= tx_next;
    end
  end

  assign full     = full_int;
  assign count    = count_reg;
  assign overflow = overflow_reg;
  assign busy     = (state_reg != S_IDLE);
  assign tx       = tx_reg;

endmodule
